// File: rtl/debug_pkg.sv
// Shared constants for the host debug unit: command codes, FSM encoding and dump sizing.
package debug_pkg;

  localparam int NBITS_DEF     = 32;
  localparam int RBITS_DEF     = 5;
  localparam int BANK_SIZE_DEF = 32;
  localparam int MEM_SIZE_DEF  = 6;

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_RUN  = 8'h52;
  localparam logic [7:0] CMD_STEP = 8'h53;

  typedef enum logic [3:0] {
    IDLE,
    LD_CNT,
    LD_BYTE,
    LD_WR,
    RUN,
    STEP,
    DUMP_RD,
    DUMP_TX,
    DUMP_WT
  } dbg_state_e;

  function automatic int bytes_per_word(input int nbits);
    return nbits / 8;
  endfunction

  function automatic int dump_words(input int bank_size, input int mem_size);
    return 1 + bank_size + (1 << mem_size);
  endfunction

  localparam int BYTES_PER_WORD = bytes_per_word(NBITS_DEF);
  localparam int DUMP_WORDS     = dump_words(BANK_SIZE_DEF, MEM_SIZE_DEF);

endpackage

// File: rtl/dbg_word_serializer.sv
// Sends one captured word as UART bytes, MSB first, with a start/done handshake per byte.
module dbg_word_serializer
  import debug_pkg::*;
#(
  parameter int NBITS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [NBITS-1:0] i_word,
  input  logic             i_tx_done,
  output logic [7:0]       o_tx_data,
  output logic             o_tx_start,
  output logic             o_done
);

  localparam int BPW    = bytes_per_word(NBITS);
  localparam int BCNT_W = $clog2(BPW + 1);

  logic [NBITS-1:0]  word_q, word_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic              busy_q, busy_d;
  logic              wait_q, wait_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_q <= '0;
      bcnt_q <= '0;
      busy_q <= 1'b0;
      wait_q <= 1'b0;
    end else begin
      word_q <= word_d;
      bcnt_q <= bcnt_d;
      busy_q <= busy_d;
      wait_q <= wait_d;
    end
  end

  always_comb begin
    word_d     = word_q;
    bcnt_d     = bcnt_q;
    busy_d     = busy_q;
    wait_d     = wait_q;
    o_tx_start = 1'b0;
    o_done     = 1'b0;
    o_tx_data  = word_q[NBITS-1 -: 8];
    if (i_load) begin
      word_d = i_word;
      bcnt_d = '0;
      busy_d = 1'b1;
      wait_d = 1'b0;
    end else if (busy_q && !wait_q) begin
      o_tx_start = 1'b1;
      wait_d     = 1'b1;
    end else if (busy_q && i_tx_done) begin
      wait_d = 1'b0;
      if (bcnt_q == BCNT_W'(BPW - 1)) begin
        busy_d = 1'b0;
        o_done = 1'b1;
      end else begin
        // shift so the next byte always sits in the top lane
        word_d = word_q << 8;
        bcnt_d = bcnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/debug_unit.sv
// Host debug unit: loads imem from UART, gates the pipeline for run/step, dumps PC/regs/dmem.
//   state   | meaning
//   IDLE    | waiting for a command byte
//   LD_CNT  | next RX byte is the word count
//   LD_BYTE | assembling an instruction word, MSB first
//   LD_WR   | one-cycle imem write
//   RUN     | pipeline enabled until halt
//   STEP    | pipeline enabled for one cycle
//   DUMP_RD | drive read address, capture word
//   DUMP_TX | byte start pulse
//   DUMP_WT | waiting for tx_done
module debug_unit
  import debug_pkg::*;
#(
  parameter int NBITS     = NBITS_DEF,
  parameter int RBITS     = RBITS_DEF,
  parameter int BANK_SIZE = BANK_SIZE_DEF,
  parameter int MEM_SIZE  = MEM_SIZE_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          i_rx_data,
  input  logic                i_rx_valid,
  output logic [7:0]          o_tx_data,
  output logic                o_tx_start,
  input  logic                i_tx_done,
  output logic                o_imem_we,
  output logic [MEM_SIZE-1:0] o_imem_addr,
  output logic [NBITS-1:0]    o_imem_data,
  output logic                o_pipe_en,
  input  logic                i_halt,
  input  logic [NBITS-1:0]    i_pc,
  output logic [RBITS-1:0]    o_reg_addr,
  input  logic [NBITS-1:0]    i_reg_data,
  output logic [MEM_SIZE-1:0] o_dmem_addr,
  input  logic [NBITS-1:0]    i_dmem_data
);

  localparam int BPW    = bytes_per_word(NBITS);
  localparam int DWORDS = dump_words(BANK_SIZE, MEM_SIZE);
  localparam int BCNT_W = $clog2(BPW + 1);
  localparam int DIDX_W = $clog2(DWORDS);

  dbg_state_e          state_q, state_d;
  logic [7:0]          ld_rem_q, ld_rem_d;
  logic [MEM_SIZE-1:0] ld_idx_q, ld_idx_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic [NBITS-1:0]    asm_q, asm_d;
  logic [DIDX_W-1:0]   didx_q, didx_d;

  logic             ser_load;
  logic             ser_done;
  logic [NBITS-1:0] cap_word;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      ld_rem_q <= '0;
      ld_idx_q <= '0;
      bcnt_q   <= '0;
      asm_q    <= '0;
      didx_q   <= '0;
    end else begin
      state_q  <= state_d;
      ld_rem_q <= ld_rem_d;
      ld_idx_q <= ld_idx_d;
      bcnt_q   <= bcnt_d;
      asm_q    <= asm_d;
      didx_q   <= didx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ld_rem_d    = ld_rem_q;
    ld_idx_d    = ld_idx_q;
    bcnt_d      = bcnt_q;
    asm_d       = asm_q;
    didx_d      = didx_q;
    o_imem_we   = 1'b0;
    o_imem_addr = '0;
    o_imem_data = '0;
    o_pipe_en   = 1'b0;
    o_reg_addr  = '0;
    o_dmem_addr = '0;
    ser_load    = 1'b0;
    cap_word    = i_pc;
    unique case (state_q)
      IDLE: begin
        if (i_rx_valid) begin
          didx_d = '0;
          if (i_rx_data == CMD_LOAD) state_d = LD_CNT;
          else if (i_rx_data == CMD_RUN) state_d = i_halt ? DUMP_RD : RUN;
          else if (i_rx_data == CMD_STEP) state_d = i_halt ? DUMP_RD : STEP;
        end
      end
      LD_CNT: begin
        if (i_rx_valid) begin
          ld_rem_d = i_rx_data;
          ld_idx_d = '0;
          bcnt_d   = '0;
          state_d  = (i_rx_data == 8'd0) ? IDLE : LD_BYTE;
        end
      end
      LD_BYTE: begin
        if (i_rx_valid) begin
          asm_d = (asm_q << 8) | NBITS'(i_rx_data);
          if (bcnt_q == BCNT_W'(BPW - 1)) begin
            bcnt_d  = '0;
            state_d = LD_WR;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end
      LD_WR: begin
        o_imem_we   = 1'b1;
        o_imem_addr = ld_idx_q;
        o_imem_data = asm_q;
        ld_idx_d    = ld_idx_q + 1'b1;
        ld_rem_d    = ld_rem_q - 8'd1;
        state_d     = (ld_rem_q == 8'd1) ? IDLE : LD_BYTE;
      end
      RUN: begin
        o_pipe_en = 1'b1;
        if (i_halt) state_d = DUMP_RD;
      end
      STEP: begin
        o_pipe_en = 1'b1;
        state_d   = DUMP_RD;
      end
      DUMP_RD: begin
        ser_load = 1'b1;
        state_d  = DUMP_TX;
        // word 0 is the PC, then the register bank, then data memory
        if (didx_q == '0) begin
          cap_word = i_pc;
        end else if (didx_q <= DIDX_W'(BANK_SIZE)) begin
          o_reg_addr = RBITS'(didx_q - DIDX_W'(1));
          cap_word   = i_reg_data;
        end else begin
          o_dmem_addr = MEM_SIZE'(didx_q - DIDX_W'(1) - DIDX_W'(BANK_SIZE));
          cap_word    = i_dmem_data;
        end
      end
      DUMP_TX: state_d = DUMP_WT;
      DUMP_WT: begin
        if (ser_done) begin
          if (didx_q == DIDX_W'(DWORDS - 1)) begin
            didx_d  = '0;
            state_d = IDLE;
          end else begin
            didx_d  = didx_q + 1'b1;
            state_d = DUMP_RD;
          end
        end else if (i_tx_done) begin
          state_d = DUMP_TX;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  dbg_word_serializer #(.NBITS(NBITS)) u_ser (
    .clk        (clk),
    .rst        (rst),
    .i_load     (ser_load),
    .i_word     (cap_word),
    .i_tx_done  (i_tx_done),
    .o_tx_data  (o_tx_data),
    .o_tx_start (o_tx_start),
    .o_done     (ser_done)
  );

endmodule

// File: tb/tb_debug_unit.sv
// Directed bench for debug_unit: load, run, step, dump stream and mid-dump reset.
module tb_debug_unit;

  localparam int NBITS      = 32;
  localparam int RBITS      = 5;
  localparam int MEM_SIZE   = 6;
  localparam int DUMP_BYTES = 388;

  logic                clk;
  logic                rst;
  logic [7:0]          i_rx_data;
  logic                i_rx_valid;
  logic [7:0]          o_tx_data;
  logic                o_tx_start;
  logic                i_tx_done;
  logic                o_imem_we;
  logic [MEM_SIZE-1:0] o_imem_addr;
  logic [NBITS-1:0]    o_imem_data;
  logic                o_pipe_en;
  logic                i_halt;
  logic [NBITS-1:0]    i_pc;
  logic [RBITS-1:0]    o_reg_addr;
  logic [NBITS-1:0]    i_reg_data;
  logic [MEM_SIZE-1:0] o_dmem_addr;
  logic [NBITS-1:0]    i_dmem_data;

  int checks   = 0;
  int failures = 0;

  int we_cnt   = 0;
  int tx_cnt   = 0;
  int pipe_cnt = 0;
  int pend     = 0;
  logic [MEM_SIZE-1:0] we_addr [16];
  logic [NBITS-1:0]    we_data [16];
  logic [7:0]          tx_log  [4096];

  debug_unit dut (
    .clk         (clk),
    .rst         (rst),
    .i_rx_data   (i_rx_data),
    .i_rx_valid  (i_rx_valid),
    .o_tx_data   (o_tx_data),
    .o_tx_start  (o_tx_start),
    .i_tx_done   (i_tx_done),
    .o_imem_we   (o_imem_we),
    .o_imem_addr (o_imem_addr),
    .o_imem_data (o_imem_data),
    .o_pipe_en   (o_pipe_en),
    .i_halt      (i_halt),
    .i_pc        (i_pc),
    .o_reg_addr  (o_reg_addr),
    .i_reg_data  (i_reg_data),
    .o_dmem_addr (o_dmem_addr),
    .i_dmem_data (i_dmem_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign i_reg_data  = 32'hA000_0000 | 32'(o_reg_addr);
  assign i_dmem_data = 32'hD000_0000 | 32'(o_dmem_addr);

  // observe on the falling edge; answer each start with tx_done two cycles later
  always @(negedge clk) begin
    if (o_imem_we) begin
      if (we_cnt < 16) begin
        we_addr[we_cnt] = o_imem_addr;
        we_data[we_cnt] = o_imem_data;
      end
      we_cnt++;
    end
    if (o_pipe_en) pipe_cnt++;
    i_tx_done = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) i_tx_done = 1'b1;
    end
    if (o_tx_start) begin
      if (tx_cnt < 4096) tx_log[tx_cnt] = o_tx_data;
      tx_cnt++;
      pend = 2;
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_rx(input logic [7:0] b);
    @(negedge clk);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    @(negedge clk);
    i_rx_valid = 1'b0;
    i_rx_data  = 8'h00;
  endtask

  function automatic logic [7:0] exp_byte(input int idx, input logic [31:0] pc);
    int w;
    int b;
    logic [31:0] word;
    w = idx / 4;
    b = idx % 4;
    if (w == 0) word = pc;
    else if (w <= 32) word = 32'hA000_0000 | 32'(w - 1);
    else word = 32'hD000_0000 | 32'(w - 33);
    return 8'(word >> (8 * (3 - b)));
  endfunction

  task automatic wait_dump(input int tx0);
    int n;
    n = 0;
    while ((tx_cnt - tx0) < DUMP_BYTES && n < 8000) begin
      @(negedge clk);
      n++;
    end
    repeat (40) @(negedge clk);
  endtask

  task automatic check_stream(input string tag, input int tx0, input logic [31:0] pc);
    int bad;
    bad = 0;
    for (int i = 0; i < DUMP_BYTES; i++)
      if (tx_log[tx0 + i] !== exp_byte(i, pc)) bad++;
    check_val(tag, 64'(bad), 64'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_tx_start"}, 64'(o_tx_start), 64'd0);
    check_val({tag, "_tx_data"}, 64'(o_tx_data), 64'd0);
    check_val({tag, "_imem_we"}, 64'(o_imem_we), 64'd0);
    check_val({tag, "_imem_addr"}, 64'(o_imem_addr), 64'd0);
    check_val({tag, "_imem_data"}, 64'(o_imem_data), 64'd0);
    check_val({tag, "_pipe_en"}, 64'(o_pipe_en), 64'd0);
    check_val({tag, "_reg_addr"}, 64'(o_reg_addr), 64'd0);
    check_val({tag, "_dmem_addr"}, 64'(o_dmem_addr), 64'd0);
  endtask

  initial begin
    int we0;
    int tx0;
    int pe0;
    int n;
    logic [31:0] w31;

    rst        = 1'b0;
    i_rx_data  = 8'h00;
    i_rx_valid = 1'b0;
    i_halt     = 1'b0;
    i_pc       = 32'h0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // load two words
    we0 = we_cnt; tx0 = tx_cnt; pe0 = pipe_cnt;
    send_rx(8'h4C); send_rx(8'h02);
    send_rx(8'h20); send_rx(8'h08); send_rx(8'h00); send_rx(8'h05);
    send_rx(8'h00); send_rx(8'h00); send_rx(8'h00); send_rx(8'h0C);
    repeat (5) @(negedge clk);
    check_val("load2_we_cycles", 64'(we_cnt - we0), 64'd2);
    check_val("load2_addr0", 64'(we_addr[we0]), 64'd0);
    check_val("load2_data0", 64'(we_data[we0]), 64'h2008_0005);
    check_val("load2_addr1", 64'(we_addr[we0 + 1]), 64'd1);
    check_val("load2_data1", 64'(we_data[we0 + 1]), 64'h0000_000C);
    check_val("load2_no_tx", 64'(tx_cnt - tx0), 64'd0);
    check_val("load2_no_pipe", 64'(pipe_cnt - pe0), 64'd0);

    // N=0 load, then a junk byte; a following load must start at address 0
    we0 = we_cnt; tx0 = tx_cnt;
    send_rx(8'h4C); send_rx(8'h00); send_rx(8'h58);
    repeat (5) @(negedge clk);
    check_val("load0_no_we", 64'(we_cnt - we0), 64'd0);
    check_val("load0_no_tx", 64'(tx_cnt - tx0), 64'd0);
    send_rx(8'h4C); send_rx(8'h01);
    send_rx(8'hDE); send_rx(8'hAD); send_rx(8'hBE); send_rx(8'hEF);
    repeat (5) @(negedge clk);
    check_val("load1_we_cycles", 64'(we_cnt - we0), 64'd1);
    check_val("load1_addr", 64'(we_addr[we0]), 64'd0);
    check_val("load1_data", 64'(we_data[we0]), 64'hDEAD_BEEF);

    // single step
    i_pc = 32'h0000_0004;
    tx0 = tx_cnt; pe0 = pipe_cnt;
    send_rx(8'h53);
    wait_dump(tx0);
    check_val("step_pipe_cycles", 64'(pipe_cnt - pe0), 64'd1);
    check_val("step_tx_count", 64'(tx_cnt - tx0), 64'(DUMP_BYTES));
    check_val("step_byte0", 64'(tx_log[tx0]), 64'h00);
    check_val("step_byte1", 64'(tx_log[tx0 + 1]), 64'h00);
    check_val("step_byte2", 64'(tx_log[tx0 + 2]), 64'h00);
    check_val("step_byte3", 64'(tx_log[tx0 + 3]), 64'h04);
    check_stream("step_stream", tx0, 32'h0000_0004);

    // run until halt, with RX traffic during the dump that must be dropped
    i_pc = 32'h0000_0040;
    tx0 = tx_cnt; pe0 = pipe_cnt; we0 = we_cnt;
    send_rx(8'h52);
    repeat (9) @(negedge clk);
    i_halt = 1'b1;
    repeat (50) @(negedge clk);
    send_rx(8'h4C); send_rx(8'h01);
    send_rx(8'h11); send_rx(8'h22); send_rx(8'h33); send_rx(8'h44);
    send_rx(8'h53);
    wait_dump(tx0);
    check_val("run_pipe_cycles", 64'(pipe_cnt - pe0), 64'd10);
    check_val("run_tx_count", 64'(tx_cnt - tx0), 64'(DUMP_BYTES));
    check_val("run_rx_dropped_we", 64'(we_cnt - we0), 64'd0);
    check_stream("run_stream", tx0, 32'h0000_0040);

    // run with halt already high
    i_pc = 32'h0000_0100;
    tx0 = tx_cnt; pe0 = pipe_cnt;
    send_rx(8'h52);
    wait_dump(tx0);
    check_val("runh_pipe_cycles", 64'(pipe_cnt - pe0), 64'd0);
    check_val("runh_tx_count", 64'(tx_cnt - tx0), 64'(DUMP_BYTES));
    w31 = {tx_log[tx0 + 128], tx_log[tx0 + 129], tx_log[tx0 + 130], tx_log[tx0 + 131]};
    check_val("runh_reg31_word", 64'(w31), 64'hA000_001F);
    check_stream("runh_stream", tx0, 32'h0000_0100);

    // reset in the middle of a dump
    i_halt = 1'b0;
    i_pc   = 32'h1234_5678;
    tx0 = tx_cnt;
    send_rx(8'h53);
    n = 0;
    while ((tx_cnt - tx0) < 100 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check_val("mid_reached", 64'((tx_cnt - tx0) >= 100), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_idle_outputs("midrst");
    @(negedge clk);
    rst = 1'b1;
    tx0 = tx_cnt;
    repeat (20) @(negedge clk);
    check_val("midrst_quiet", 64'(tx_cnt - tx0), 64'd0);
    i_pc = 32'hCAFE_F00D;
    tx0 = tx_cnt; pe0 = pipe_cnt;
    send_rx(8'h53);
    wait_dump(tx0);
    check_val("after_rst_pipe", 64'(pipe_cnt - pe0), 64'd1);
    check_val("after_rst_tx_count", 64'(tx_cnt - tx0), 64'(DUMP_BYTES));
    check_val("after_rst_byte0", 64'(tx_log[tx0]), 64'hCA);
    check_stream("after_rst_stream", tx0, 32'hCAFE_F00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
